// File: rtl/xc_aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xc_aes_pkg
//  Brief    : Shared definitions for the AES instruction units (SubBytes and
//             MixColumns): FSM encoding, field constants, xtime2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package xc_aes_pkg;

   // Sequencer states of the multi-cycle SubBytes unit
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Reduction polynomial x^8+x^4+x^3+x+1 with the x^8 term dropped
   localparam logic [7:0] AES_POLY         = 8'h1b;
   // Additive constants of the forward and inverse affine maps
   localparam logic [7:0] AES_AFFINE_C     = 8'h63;
   localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;

   // Multiply by x in GF(2^8) modulo the AES polynomial
   function automatic logic [7:0] xtime2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/xc_aessub_if.sv
`default_nettype none
// ============================================================================
//  Module   : xc_aessub_if
//  Brief    : Request/response bundle of the SubBytes instruction unit.
//             The core side drives the request (master), the unit answers
//             with ready/result (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface xc_aessub_if;
   logic        valid;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        enc;
   logic        ready;
   logic [31:0] result;

   modport master (
      output valid, rs1, rs2, enc,
      input  ready, result
   );

   modport slave (
      input  valid, rs1, rs2, enc,
      output ready, result
   );
endinterface
`default_nettype wire

// File: rtl/xc_aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : xc_aes_sbox
//  Brief    : Combinational AES S-box / inverse S-box. Inversion in GF(2^8)
//             is computed as x^254 with a square-and-multiply chain, so no
//             256-entry table is needed; inv(0) falls out as 0.
//  Revision : 1.0 - initial release
// ============================================================================
module xc_aes_sbox
   import xc_aes_pkg::*;
(
   input  logic [7:0] in,
   input  logic       enc,
   output logic [7:0] out
);

   // GF(2^8) multiply: shift-and-add with xtime2 doing the reduction
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime2(t);
      end
      return p;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128, which is x^-1 for x != 0 and 0 for 0
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = gf_mul(x, x);
      r = p;
      for (int i = 2; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ AES_AFFINE_C;
   endfunction

   // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]}
             ^ AES_INV_AFFINE_C;
   endfunction

   // Select the forward or inverse substitution path
   always_comb begin
      out = 8'h00;
      if (enc) out = affine_fwd(gf_inv(in));
      else     out = gf_inv(affine_inv(in));
   end

endmodule
`default_nettype wire

// File: rtl/xc_aessub.sv
`default_nettype none
// ============================================================================
//  Module   : xc_aessub
//  Brief    : Multi-cycle AES SubBytes / InvSubBytes instruction unit.
//             Bytes are gathered with ShiftRows folded in
//             (b0=rs1[7:0], b1=rs1[15:8], b2=rs2[23:16], b3=rs2[31:24]) and
//             substituted by a time-multiplexed S-box datapath.
//             Build option XC_AESSUB_FAST_EN: two S-box lanes, two BUSY
//             cycles instead of four; results are identical.
//  Revision : 1.0 - initial release
// ============================================================================
module xc_aessub
   import xc_aes_pkg::*;
#(
   parameter bit MASK_OUT = 1'b1
)(
   input  logic         clock,
   input  logic         reset,
   xc_aessub_if.slave   bus
);

`ifdef XC_AESSUB_FAST_EN
   localparam int LANES = 2;
`else
   localparam int LANES = 1;
`endif
   // One count step per BUSY cycle; LANES bytes are written per step
   localparam int              CNT_W    = (LANES == 2) ? 1 : 2;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [31:0]        ops_q,   ops_d;
   logic               enc_q,   enc_d;
   logic [31:0]        acc_q,   acc_d;
   logic               ready;

   logic [7:0]         sb_in  [LANES];
   logic [7:0]         sb_out [LANES];

   // Operand bits that never take part in the byte gathering
   logic               unused_bits;
   assign unused_bits = ^{bus.rs1[31:16], bus.rs2[15:0]};

   // S-box lanes: lane l handles byte cnt*LANES + l of the latched operands
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign sb_in[l] = ops_q[8*(int'(cnt_q)*LANES + l) +: 8];

      xc_aes_sbox u_sbox (
         .in  (sb_in[l]),
         .enc (enc_q),
         .out (sb_out[l])
      );
   end

   // Sequencer next state, operand capture and accumulator update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ops_d   = ops_q;
      enc_d   = enc_q;
      acc_d   = acc_q;
      ready   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.valid) begin
               ops_d   = {bus.rs2[31:16], bus.rs1[15:0]};
               enc_d   = bus.enc;
               cnt_d   = '0;
               acc_d   = 32'h0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!bus.valid) begin
               // Request withdrawn: drop the partial result silently
               state_d = ST_IDLE;
            end else begin
               for (int l = 0; l < LANES; l++) begin
                  acc_d[8*(int'(cnt_q)*LANES + l) +: 8] = sb_out[l];
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Completion is only signalled while the request is still held
            ready   = bus.valid;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ops_q   <= 32'h0;
         enc_q   <= 1'b0;
         acc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ops_q   <= ops_d;
         enc_q   <= enc_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.ready  = ready;
   assign bus.result = (MASK_OUT && !ready) ? 32'h0 : acc_q;

endmodule
`default_nettype wire

// File: tb/tb_xc_aessub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xc_aessub
//  Brief    : Self-checking bench for xc_aessub. The reference S-box tables
//             are derived from the field definition (brute-force inverse,
//             bitwise affine formula). Expected latency follows the
//             XC_AESSUB_FAST_EN build option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xc_aessub;

`ifdef XC_AESSUB_FAST_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 5;
`endif
   localparam int BUDGET = 20;

   logic clock = 1'b0;
   logic reset;

   xc_aessub_if bus ();

   xc_aessub #(.MASK_OUT(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   // Reference GF(2^8) multiply with plain integer arithmetic
   function automatic int gmul(input int a, input int b);
      int p  = 0;
      int aa = a;
      for (int i = 0; i < 8; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
      end
      return p;
   endfunction

   // Multiplicative inverse by exhaustive search, inv(0) = 0
   function automatic int ginv(input int a);
      if (a == 0) return 0;
      for (int b = 1; b < 256; b++) begin
         if (gmul(a, b) == 1) return b;
      end
      return 0;
   endfunction

   // FIPS-197 affine transform, bit by bit
   function automatic int aff(input int x);
      int y = 0;
      for (int i = 0; i < 8; i++) begin
         y = y | ((((x >> i) ^ (x >> ((i + 4) % 8)) ^ (x >> ((i + 5) % 8))
                  ^ (x >> ((i + 6) % 8)) ^ (x >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1) << i);
      end
      return y;
   endfunction

   // Expected result for one instruction
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic e);
      logic [7:0]  bytes [4];
      logic [31:0] r;
      bytes[0] = a[7:0];
      bytes[1] = a[15:8];
      bytes[2] = b[23:16];
      bytes[3] = b[31:24];
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = e ? fwd_tab[bytes[i]] : inv_tab[bytes[i]];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One instruction: raise valid, wait for ready, check latency and result.
   // exp_lat is counted in cycles from the call; hold keeps valid high so the
   // next call starts a back-to-back instruction.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic e,
                        input logic [31:0] exp, input int exp_lat, input bit hold,
                        input string tag, output logic [31:0] got);
      int n;
      int acc_n;
      acc_n     = exp_lat - LAT + 1;
      bus.valid = 1'b1;
      bus.rs1   = a;
      bus.rs2   = b;
      bus.enc   = e;
      n = 0;
      do begin
         @(posedge clock);
         @(negedge clock);
         n++;
         if (!bus.ready) begin
            check({tag, "_mask"}, bus.result, 32'h0);
            if (n >= acc_n) begin
               bus.rs1 = $urandom();
               bus.rs2 = $urandom();
               bus.enc = 1'($urandom_range(0, 1));
            end
         end
      end while (!bus.ready && n < BUDGET);
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      got = bus.result;
      check(tag, bus.result, exp);
      if (!hold) begin
         bus.valid = 1'b0;
         #1;
         check({tag, "_drop"}, 32'(bus.ready), 32'h0);
         @(posedge clock);
         @(negedge clock);
         check({tag, "_pulse"}, 32'(bus.ready), 32'h0);
      end
   endtask

   logic [31:0] a, b, c, got, orig;
   logic        e;
   bit          hold, prev_hold;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int x = 0; x < 256; x++) begin
         int f;
         f = aff(ginv(x));
         fwd_tab[x] = 8'(f);
         inv_tab[f] = 8'(x);
      end

      reset     = 1'b1;
      bus.valid = 1'b0;
      bus.rs1   = 32'h0;
      bus.rs2   = 32'h0;
      bus.enc   = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_ready", 32'(bus.ready), 32'h0);
      check("rst_result", bus.result, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_ready", 32'(bus.ready), 32'h0);

      // Directed vectors
      do_op(32'h0000_0100, 32'h5310_0000, 1'b1, 32'hEDCA_7C63, LAT, 1'b0, "enc_vec", got);
      do_op(32'h0000_7C63, 32'hEDCA_0000, 1'b0, 32'h5310_0100, LAT, 1'b0, "dec_vec", got);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1616_1616, LAT, 1'b0, "enc_ff", got);
      do_op(32'h1616_1616, 32'h1616_1616, 1'b0, 32'hFFFF_FFFF, LAT, 1'b0, "dec_16", got);

      // Abort in the second BUSY cycle
      bus.valid = 1'b1;
      bus.rs1   = 32'h0000_0100;
      bus.rs2   = 32'h5310_0000;
      bus.enc   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      @(posedge clock);
      @(negedge clock);
      bus.valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock);
         @(negedge clock);
         check("abort_noready", 32'(bus.ready), 32'h0);
      end
      do_op(32'h0000_7C63, 32'hEDCA_0000, 1'b0, 32'h5310_0100, LAT, 1'b0, "after_abort", got);

      // Asynchronous reset during BUSY
      bus.valid = 1'b1;
      bus.rs1   = 32'h1234_5678;
      bus.rs2   = 32'h9ABC_DEF0;
      bus.enc   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst_busy_ready", 32'(bus.ready), 32'h0);
      check("rst_busy_result", bus.result, 32'h0);
      bus.valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1),
            LAT, 1'b0, "after_rst", got);

      // Asynchronous reset while ready is high
      do_op(32'hCAFE_0102, 32'h0304_BEEF, 1'b1, model(32'hCAFE_0102, 32'h0304_BEEF, 1'b1),
            LAT, 1'b1, "pre_rst_done", got);
      reset = 1'b1;
      #1;
      check("rst_done_ready", 32'(bus.ready), 32'h0);
      check("rst_done_result", bus.result, 32'h0);
      bus.valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // Directed back-to-back pair
      do_op(32'h0000_0100, 32'h5310_0000, 1'b1, 32'hEDCA_7C63, LAT, 1'b1, "b2b_0", got);
      do_op(32'h0000_7C63, 32'hEDCA_0000, 1'b0, 32'h5310_0100, LAT + 1, 1'b0, "b2b_1", got);

      // Exhaustive round trip over all byte values
      for (int g = 0; g < 64; g++) begin
         orig = {8'(4*g + 3), 8'(4*g + 2), 8'(4*g + 1), 8'(4*g)};
         a = {16'($urandom()), orig[15:0]};
         b = {orig[31:16], 16'($urandom())};
         do_op(a, b, 1'b1, model(a, b, 1'b1), LAT, 1'b0, "rt_enc", c);
         a = {16'($urandom()), c[15:0]};
         b = {c[31:16], 16'($urandom())};
         do_op(a, b, 1'b0, orig, LAT, 1'b0, "rt_dec", got);
      end

      // Random operands, random back-to-back chaining
      prev_hold = 1'b0;
      for (int i = 0; i < 24; i++) begin
         a    = $urandom();
         b    = $urandom();
         e    = 1'($urandom_range(0, 1));
         hold = (i != 23) && ($urandom_range(0, 1) == 1);
         do_op(a, b, e, model(a, b, e), prev_hold ? LAT + 1 : LAT, hold, "rand", got);
         prev_hold = hold;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
